motor_fault_monitor: RTL and testbench

MOTOR_FAULT_MONITOR -- requirements
Module: motor_fault_monitor

---
 rtl/motor_fault_pkg.sv | 25 ++
 rtl/motor_fault_chan.sv | 102 ++++++++++
 rtl/motor_fault_monitor.sv | 55 +++++
 tb/tb_motor_fault_monitor.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/motor_fault_pkg.sv
// Shared types for the motor fault monitor: FSM states, fault codes, counter width.
// Pure declarations; no latency, no backpressure.
package motor_fault_pkg;

  localparam int CODE_W = 2;
  localparam int CNT_W  = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_NORMAL  = 2'd0;
  localparam state_t ST_PENDING = 2'd1;
  localparam state_t ST_FAULT   = 2'd2;

  typedef enum logic [CODE_W-1:0] {
    CODE_NONE  = 2'b00,
    CODE_OC    = 2'b01,
    CODE_STALL = 2'b10,
    CODE_RSVD  = 2'b11
  } fault_code_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/motor_fault_chan.sv
// One channel: overcurrent/stall persistence FSM with latched code; outputs registered,
// one cycle after the completing sample; no backpressure (samples are never stalled).
module motor_fault_chan
  import motor_fault_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PERSIST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_cur,
  input  logic [DATA_W-1:0] i_spd,
  input  logic [DATA_W-1:0] i_oc_thr,
  input  logic [DATA_W-1:0] i_stall_i_thr,
  input  logic [DATA_W-1:0] i_stall_spd_thr,
  input  logic              i_clr,
  output logic              o_det,
  output logic [CODE_W-1:0] o_code
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(PERSIST);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  fault_code_t      r_code;

  logic             w_oc;
  logic             w_stall;
  logic             w_qual;
  fault_code_t      w_code;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_oc      = i_cur > i_oc_thr;
  assign w_stall   = (i_cur > i_stall_i_thr) && (i_spd < i_stall_spd_thr);
  assign w_qual    = w_oc || w_stall;
  assign w_code    = w_oc ? CODE_OC : CODE_STALL;
  assign w_cnt_nxt = sat_inc(r_cnt, LIM);

`ifdef MOTOR_FAULT_AUTOCLR_EN
  logic [CNT_W-1:0] r_rec;
  logic [CNT_W-1:0] w_rec_nxt;
  assign w_rec_nxt = sat_inc(r_rec, LIM);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_NORMAL;
      r_cnt   <= '0;
      r_code  <= CODE_NONE;
`ifdef MOTOR_FAULT_AUTOCLR_EN
      r_rec   <= '0;
`endif
    end else if (i_clr) begin
      // Clear beats any coincident sample; NORMAL already holds the cleared values.
      if (r_state != ST_NORMAL) begin
        r_state <= ST_NORMAL;
        r_cnt   <= '0;
        r_code  <= CODE_NONE;
`ifdef MOTOR_FAULT_AUTOCLR_EN
        r_rec   <= '0;
`endif
      end
    end else if (i_vld) begin
      case (r_state)
        ST_NORMAL, ST_PENDING: begin
          if (w_qual) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == LIM) begin
              r_state <= ST_FAULT;
              r_code  <= w_code;
            end else begin
              r_state <= ST_PENDING;
            end
          end else begin
            r_state <= ST_NORMAL;
            r_cnt   <= '0;
          end
        end
        ST_FAULT: begin
`ifdef MOTOR_FAULT_AUTOCLR_EN
          if (w_qual) begin
            r_rec <= '0;
          end else if (w_rec_nxt == LIM) begin
            r_state <= ST_NORMAL;
            r_cnt   <= '0;
            r_code  <= CODE_NONE;
            r_rec   <= '0;
          end else begin
            r_rec <= w_rec_nxt;
          end
`endif
        end
        default: r_state <= ST_NORMAL;
      endcase
    end
  end

  assign o_det  = (r_state == ST_FAULT);
  assign o_code = r_code;

endmodule

// File: rtl/motor_fault_monitor.sv
// Multi-channel motor fault monitor; optional auto-recovery with MOTOR_FAULT_AUTOCLR_EN.
// Flags register one cycle after the completing sample; fault_irq pulses with them; no backpressure.
module motor_fault_monitor
  import motor_fault_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 16,
  parameter int PERSIST = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] current_in,
  input  logic [NUM_CH*DATA_W-1:0] speed_in,
  input  logic [DATA_W-1:0]        oc_thresh,
  input  logic [DATA_W-1:0]        stall_i_thresh,
  input  logic [DATA_W-1:0]        stall_spd_thresh,
  input  logic [NUM_CH-1:0]        fault_clear,
  output logic [NUM_CH-1:0]        fault_detected,
  output logic [CODE_W*NUM_CH-1:0] fault_code,
  output logic                     fault_any,
  output logic                     fault_irq
);

  logic [NUM_CH-1:0] r_det_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    motor_fault_chan #(
      .DATA_W  (DATA_W),
      .PERSIST (PERSIST)
    ) u_chan (
      .clk             (clk),
      .rst             (rst),
      .i_vld           (sample_valid[g]),
      .i_cur           (current_in[g*DATA_W +: DATA_W]),
      .i_spd           (speed_in[g*DATA_W +: DATA_W]),
      .i_oc_thr        (oc_thresh),
      .i_stall_i_thr   (stall_i_thresh),
      .i_stall_spd_thr (stall_spd_thresh),
      .i_clr           (fault_clear[g]),
      .o_det           (fault_detected[g]),
      .o_code          (fault_code[g*CODE_W +: CODE_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_det_d <= '0;
    else     r_det_d <= fault_detected;
  end

  // Rising edge of any flag; channels faulting together share one pulse.
  assign fault_any = |fault_detected;
  assign fault_irq = |(fault_detected & ~r_det_d);

endmodule

// File: tb/tb_motor_fault_monitor.sv
// Directed bench for motor_fault_monitor (NUM_CH=4, DATA_W=16, PERSIST=8).
module tb_motor_fault_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sample_valid = '0;
  logic [63:0] current_in = '0;
  logic [63:0] speed_in = '0;
  logic [15:0] oc_thresh = 16'd1000;
  logic [15:0] stall_i_thresh = 16'd600;
  logic [15:0] stall_spd_thresh = 16'd100;
  logic [3:0]  fault_clear = '0;
  logic [3:0]  fault_detected;
  logic [7:0]  fault_code;
  logic        fault_any;
  logic        fault_irq;

  int checks = 0;
  int failures = 0;
  int irq_cnt = 0;

  motor_fault_monitor #(.NUM_CH(4), .DATA_W(16), .PERSIST(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .sample_valid     (sample_valid),
    .current_in       (current_in),
    .speed_in         (speed_in),
    .oc_thresh        (oc_thresh),
    .stall_i_thresh   (stall_i_thresh),
    .stall_spd_thresh (stall_spd_thresh),
    .fault_clear      (fault_clear),
    .fault_detected   (fault_detected),
    .fault_code       (fault_code),
    .fault_any        (fault_any),
    .fault_irq        (fault_irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (fault_irq === 1'b1) irq_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic smp(input logic [3:0] m, input int cur, input int spd, input logic [3:0] clr);
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        current_in[c*16 +: 16] = 16'(cur);
        speed_in[c*16 +: 16]   = 16'(spd);
      end
    end
    sample_valid = m;
    fault_clear  = clr;
    @(posedge clk);
    #1;
    sample_valid = '0;
    fault_clear  = '0;
  endtask

  task automatic clr(input logic [3:0] m);
    smp(4'b0000, 0, 0, m);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    idle(2);
    chk("rst_det", 32'(fault_detected), 32'h0);
    chk("rst_code", 32'(fault_code), 32'h0);
    chk("rst_any", 32'(fault_any), 32'h0);
    chk("rst_irq", 32'(fault_irq), 32'h0);
    rst = 1'b0;
    idle(1);

    // Ch0 nominal operation never faults
    repeat (100) smp(4'b0001, 500, 1500, 4'b0000);
    chk("nom_det0", 32'(fault_detected[0]), 32'h0);
    chk("nom_code0", 32'(fault_code[1:0]), 32'h0);
    chk("nom_any", 32'(fault_any), 32'h0);
    chk("nom_irq", 32'(irq_cnt), 32'd0);

    // Ch1 overcurrent persistence
    repeat (7) smp(4'b0010, 1200, 0, 4'b0000);
    chk("oc7_det1", 32'(fault_detected[1]), 32'h0);
    smp(4'b0010, 1200, 0, 4'b0000);
    chk("oc8_det1", 32'(fault_detected[1]), 32'h1);
    chk("oc8_code1", 32'(fault_code[3:2]), 32'h1);
    chk("oc8_irq_now", 32'(fault_irq), 32'h1);
    chk("oc8_any", 32'(fault_any), 32'h1);
    idle(1);
    chk("oc_irq_drop", 32'(fault_irq), 32'h0);
    chk("oc_hold_det1", 32'(fault_detected[1]), 32'h1);
    chk("oc_irq_cnt", 32'(irq_cnt), 32'd1);
    clr(4'b0010);
    chk("clr_det1", 32'(fault_detected[1]), 32'h0);
    chk("clr_code1", 32'(fault_code[3:2]), 32'h0);
    repeat (7) smp(4'b0010, 1200, 0, 4'b0000);
    smp(4'b0010, 500, 0, 4'b0000);
    chk("break_det1", 32'(fault_detected[1]), 32'h0);
    smp(4'b0010, 1200, 0, 4'b0000);
    chk("restart_det1", 32'(fault_detected[1]), 32'h0);
    clr(4'b0010);

    // Ch2 stall with sparse valid
    for (int i = 0; i < 8; i++) begin
      smp(4'b0100, 700, 50, 4'b0000);
      if (i == 6) chk("st7_det2", 32'(fault_detected[2]), 32'h0);
      if (i == 7) begin
        chk("st8_det2", 32'(fault_detected[2]), 32'h1);
        chk("st8_code2", 32'(fault_code[5:4]), 32'h2);
      end
      idle(1);
    end
    clr(4'b0100);
    repeat (8) smp(4'b0100, 1000, 50, 4'b0000);
    chk("eq_thr_code2", 32'(fault_code[5:4]), 32'h2);
    clr(4'b0100);
    repeat (7) smp(4'b0100, 700, 50, 4'b0000);
    smp(4'b0100, 1200, 50, 4'b0000);
    chk("mix_det2", 32'(fault_detected[2]), 32'h1);
    chk("mix_code2", 32'(fault_code[5:4]), 32'h1);
    clr(4'b0100);
    chk("st_irq_cnt", 32'(irq_cnt), 32'd4);

    // Ch3 clear racing the completing sample
    repeat (7) smp(4'b1000, 1200, 0, 4'b0000);
    smp(4'b1000, 1200, 0, 4'b1000);
    chk("race_det3", 32'(fault_detected[3]), 32'h0);
    chk("race_code3", 32'(fault_code[7:6]), 32'h0);
    repeat (7) smp(4'b1000, 1200, 0, 4'b0000);
    chk("race7_det3", 32'(fault_detected[3]), 32'h0);
    smp(4'b1000, 1200, 0, 4'b0000);
    chk("race8_det3", 32'(fault_detected[3]), 32'h1);
    clr(4'b1000);
    chk("clrf_det3", 32'(fault_detected[3]), 32'h0);
    chk("clrf_any", 32'(fault_any), 32'h0);

    // Two channels faulting together give one pulse
    repeat (8) smp(4'b1001, 1200, 0, 4'b0000);
    chk("dual_det", 32'(fault_detected), 32'h9);
    chk("dual_code", 32'(fault_code), 32'h41);
    idle(1);
    chk("dual_irq_cnt", 32'(irq_cnt), 32'd6);
    clr(4'b1001);

    // Threshold moved mid-pending keeps the count
    repeat (4) smp(4'b0001, 1200, 1500, 4'b0000);
    oc_thresh = 16'd1100;
    repeat (4) smp(4'b0001, 1200, 1500, 4'b0000);
    chk("thr_det0", 32'(fault_detected[0]), 32'h1);
    oc_thresh = 16'd1000;
    clr(4'b0001);

    // Async reset abandons latched and pending faults
    repeat (8) smp(4'b0001, 1200, 1500, 4'b0000);
    chk("pre_rst_det0", 32'(fault_detected[0]), 32'h1);
    repeat (5) smp(4'b0010, 1200, 0, 4'b0000);
    #2 rst = 1'b1;
    #1;
    chk("arst_det", 32'(fault_detected), 32'h0);
    chk("arst_code", 32'(fault_code), 32'h0);
    chk("arst_any", 32'(fault_any), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (7) smp(4'b0010, 1200, 0, 4'b0000);
    chk("post_rst7_det1", 32'(fault_detected[1]), 32'h0);
    smp(4'b0010, 1200, 0, 4'b0000);
    chk("post_rst8_det1", 32'(fault_detected[1]), 32'h1);
    idle(1);
    chk("final_irq_cnt", 32'(irq_cnt), 32'd9);

    // Recovery behaviour on benign samples
    repeat (8) smp(4'b0010, 500, 1500, 4'b0000);
`ifdef MOTOR_FAULT_AUTOCLR_EN
    chk("recov_det1", 32'(fault_detected[1]), 32'h0);
    chk("recov_code1", 32'(fault_code[3:2]), 32'h0);
`else
    chk("recov_det1", 32'(fault_detected[1]), 32'h1);
    chk("recov_code1", 32'(fault_code[3:2]), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
